mic_fir_mac: RTL and testbench

//   Parametrised, time-multiplexed signed FIR filter for the microphone path.
//   A single multiply-accumulate unit iterates over a TAPS-deep sample ring buffer.

---
 rtl/mic_pkg.sv | 27 ++
 rtl/mic_fir_mac_unit.sv | 38 +++
 rtl/mic_fir_mac.sv | 163 ++++++++++++++++
 tb/tb_mic_fir_mac.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mic_pkg.sv
// Shared widths, types, FSM states and output scaling for the microphone FIR MAC.
package mic_pkg;

    localparam int DATA_W = 24;
    localparam int COEF_W = 16;
    localparam int ACC_W  = 48;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} state_t;

    localparam acc_t SAT_MAX = acc_t'(2**(DATA_W-1) - 1);
    localparam acc_t SAT_MIN = acc_t'(-(2**(DATA_W-1)));

    function automatic sample_t sat_shift(acc_t acc, int shift);
        acc_t s;
        s = acc >>> shift;
        if (s > SAT_MAX)
            s = SAT_MAX;
        else if (s < SAT_MIN)
            s = SAT_MIN;
        return sample_t'(s);
    endfunction

endpackage

// File: rtl/mic_fir_mac_unit.sv
// Two-stage signed MAC: registered full-precision product, then accumulate.
// acc_sum folds in the product still in flight so the caller can scale one cycle earlier.
module mic_fir_mac_unit
    import mic_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      vld_in,
    input  logic signed [DATA_W:0]    a,
    input  logic signed [COEF_W-1:0]  b,
    output logic signed [ACC_W-1:0]   acc_sum
);

    acc_t prod_p0;
    acc_t acc_p1;
    logic vld_p0;

    // Stage 0: product register
    always_ff @(posedge clk) begin
        prod_p0 <= acc_t'(a) * acc_t'(b);
        if (rst)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= vld_in;
    end

    // Stage 1: accumulator
    always_ff @(posedge clk) begin
        if (clr)
            acc_p1 <= '0;
        else if (vld_p0)
            acc_p1 <= acc_p1 + prod_p0;
    end

    assign acc_sum = vld_p0 ? acc_p1 + prod_p0 : acc_p1;

endmodule

// File: rtl/mic_fir_mac.sv
// Time-multiplexed FIR for the mic path: ring buffer, runtime coefficients, decimation, saturation.
// Define MIC_FIR_SYM_EN for symmetric (linear-phase) mode with ceil(TAPS/2) coefficients.
module mic_fir_mac
    import mic_pkg::*;
#(
    parameter  int TAPS      = 23,
    parameter  int OUT_SHIFT = 15,
    parameter  int DECIM     = 1,
    localparam int PTR_W     = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_rdy,
    input  logic              coef_we,
    input  logic [PTR_W-1:0]  coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_rdy,
    output logic              busy,
    output logic              overrun
);

`ifdef MIC_FIR_SYM_EN
    localparam int NMAC = (TAPS + 1) / 2;
`else
    localparam int NMAC = TAPS;
`endif
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TAPS - 1);
    localparam logic [PTR_W-1:0] K_LAST   = PTR_W'(NMAC - 1);
    localparam int               DEC_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);

    state_t               state;
    sample_t              sbuf [TAPS];
    coef_t                coef [TAPS];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     wr_ptr_nxt;
    logic [PTR_W-1:0]     rd_a;
    logic [PTR_W-1:0]     k;
    logic [DEC_W-1:0]     dec_cnt;
    logic                 pend_vld;
    logic [PTR_W-1:0]     pend_addr;
    coef_t                pend_data;
    logic                 coef_ok;
    logic                 accept;
    logic                 drop;
    logic                 start;
    logic signed [DATA_W:0] mac_a;
    acc_t                 acc_sum;
`ifdef MIC_FIR_SYM_EN
    logic [PTR_W-1:0]     rd_b;
`endif

    assign coef_ok    = coef_we && (coef_addr <= K_LAST);
    assign accept     = data_in_rdy && enable && !busy;
    assign drop       = data_in_rdy && enable && busy;
    assign start      = accept && (dec_cnt == DEC_LAST);
    assign wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;

    // rd_a walks back from the newest sample; in symmetric mode rd_b walks forward from the oldest
    always_comb begin
        mac_a = {sbuf[rd_a][DATA_W-1], sbuf[rd_a]};
`ifdef MIC_FIR_SYM_EN
        if (!((TAPS % 2 == 1) && (k == K_LAST)))
            mac_a = mac_a + {sbuf[rd_b][DATA_W-1], sbuf[rd_b]};
`endif
    end

    mic_fir_mac_unit u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr     (start),
        .vld_in  (state == MAC),
        .a       (mac_a),
        .b       (coef[k]),
        .acc_sum (acc_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            data_out     <= '0;
            data_out_rdy <= 1'b0;
            overrun      <= 1'b0;
            wr_ptr       <= '0;
            rd_a         <= '0;
            k            <= '0;
            dec_cnt      <= '0;
            pend_vld     <= 1'b0;
            pend_addr    <= '0;
            pend_data    <= '0;
            for (int i = 0; i < TAPS; i++) begin
                sbuf[i] <= '0;
                coef[i] <= '0;
            end
        end else begin
            overrun      <= drop;
            data_out_rdy <= 1'b0;
            if (accept) begin
                sbuf[wr_ptr] <= data_in;
                wr_ptr       <= wr_ptr_nxt;
                dec_cnt      <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
            end
            if (coef_ok && (state == MAC || state == SCALE)) begin
                pend_vld  <= 1'b1;
                pend_addr <= coef_addr;
                pend_data <= coef_data;
            end
            case (state)
                IDLE: begin
                    if (coef_ok)
                        coef[coef_addr] <= coef_data;
                    if (start) begin
                        state <= MAC;
                        busy  <= 1'b1;
                        k     <= '0;
                        rd_a  <= wr_ptr;
                    end
                end
                MAC: begin
                    k    <= k + 1'b1;
                    rd_a <= (rd_a == '0) ? PTR_LAST : rd_a - 1'b1;
                    if (k == K_LAST)
                        state <= SCALE;
                end
                SCALE: begin
                    data_out     <= sat_shift(acc_sum, OUT_SHIFT);
                    data_out_rdy <= 1'b1;
                    state        <= OUT;
                end
                OUT: begin
                    // a write arriving now is newer than the pending one, so it lands last
                    if (pend_vld)
                        coef[pend_addr] <= pend_data;
                    if (coef_ok)
                        coef[coef_addr] <= coef_data;
                    pend_vld <= 1'b0;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MIC_FIR_SYM_EN
    always_ff @(posedge clk) begin
        if (rst)
            rd_b <= '0;
        else if (state == IDLE && start)
            rd_b <= wr_ptr_nxt;
        else if (state == MAC)
            rd_b <= (rd_b == PTR_LAST) ? '0 : rd_b + 1'b1;
    end
`endif

endmodule

// File: tb/tb_mic_fir_mac.sv
// Directed bench for mic_fir_mac (TAPS=23, OUT_SHIFT=14; second instance with DECIM=4).
module tb_mic_fir_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [23:0] data_in = '0;
    logic        data_in_rdy = 1'b0;
    logic        coef_we = 1'b0;
    logic [4:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic [23:0] data_out, d4_out;
    logic        data_out_rdy, busy, overrun;
    logic        d4_rdy, d4_busy, d4_overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mic_fir_mac #(.TAPS(23), .OUT_SHIFT(14), .DECIM(1)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .data_in(data_in), .data_in_rdy(data_in_rdy),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .data_out(data_out), .data_out_rdy(data_out_rdy),
        .busy(busy), .overrun(overrun)
    );

    mic_fir_mac #(.TAPS(23), .OUT_SHIFT(14), .DECIM(4)) dut_d4 (
        .clk(clk), .rst(rst), .enable(enable),
        .data_in(data_in), .data_in_rdy(data_in_rdy),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .data_out(d4_out), .data_out_rdy(d4_rdy),
        .busy(d4_busy), .overrun(d4_overrun)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic wr_coef(input logic [4:0] a, input logic [15:0] v);
        coef_we = 1'b1;
        coef_addr = a;
        coef_data = v;
        step(1);
        coef_we = 1'b0;
    endtask

    // Accepting edge is the next posedge; returns in cycle 1 after it.
    task automatic send(input logic [23:0] v);
        data_in = v;
        data_in_rdy = 1'b1;
        step(1);
        data_in_rdy = 1'b0;
    endtask

    // Polls from the current cycle (numbered 1); leaves one cycle after the pulse.
    task automatic wait_out(output int lat, output logic [23:0] val);
        bit found = 0;
        lat = -1;
        val = '0;
        for (int i = 1; i <= 60 && !found; i++) begin
            if (data_out_rdy) begin
                lat = i;
                val = data_out;
                found = 1;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (data_out !== 24'h0) begin errors++; $display("FAIL reset_data_out: got %h want 000000", data_out); end
        checks++; if (data_out_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", data_out_rdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_single();
        int lat;
        logic [23:0] val;
        wr_coef(5'd0, 16'h4000);
        send(24'h001234);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_c1: got %b want 1", busy); end
        wait_out(lat, val);
        checks++; if (lat !== 25) begin errors++; $display("FAIL single_latency: got %0d want 25", lat); end
        checks++; if (val !== 24'h001234) begin errors++; $display("FAIL single_value: got %h want 001234", val); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_c26: got %b want 0", busy); end
        checks++; if (data_out_rdy !== 1'b0) begin errors++; $display("FAIL single_rdy_width: got %b want 0", data_out_rdy); end
        checks++; if (data_out !== 24'h001234) begin errors++; $display("FAIL single_hold: got %h want 001234", data_out); end
    endtask

    task automatic test_negative();
        int lat;
        logic [23:0] val;
        send(24'hFFFF00);
        wait_out(lat, val);
        checks++; if (lat !== 25) begin errors++; $display("FAIL neg_latency: got %0d want 25", lat); end
        checks++; if (val !== 24'hFFFF00) begin errors++; $display("FAIL neg_value: got %h want ffff00", val); end
    endtask

    task automatic test_saturation();
        int lat;
        logic [23:0] val;
        do_reset();
        for (int a = 0; a < 23; a++) wr_coef(5'(a), 16'h7FFF);
        for (int s = 0; s < 23; s++) begin
            send(24'h7FFFFF);
            wait_out(lat, val);
        end
        checks++; if (val !== 24'h7FFFFF) begin errors++; $display("FAIL sat_pos: got %h want 7fffff", val); end
        for (int s = 0; s < 23; s++) begin
            send(24'h800000);
            wait_out(lat, val);
        end
        checks++; if (val !== 24'h800000) begin errors++; $display("FAIL sat_neg: got %h want 800000", val); end
    endtask

    task automatic test_overrun();
        int lat;
        int seen;
        logic [23:0] val;
        do_reset();
        wr_coef(5'd0, 16'h4000);
        wr_coef(5'd1, 16'h2000);
        send(24'h000100);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_idle: got %b want 0", overrun); end
        step(4);
        send(24'h000777);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
        step(1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_width: got %b want 0", overrun); end
        wait_out(lat, val);
        checks++; if (val !== 24'h000100) begin errors++; $display("FAIL ovr_first: got %h want 000100", val); end
        send(24'h000200);
        wait_out(lat, val);
        checks++; if (val !== 24'h000280) begin errors++; $display("FAIL ovr_buffer: got %h want 000280", val); end
        enable = 1'b0;
        send(24'h000999);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL disabled_busy: got %b want 0", busy); end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (data_out_rdy) seen++;
            step(1);
        end
        enable = 1'b1;
        checks++; if (seen !== 0) begin errors++; $display("FAIL disabled_out: got %0d pulses want 0", seen); end
    endtask

    task automatic test_decim();
        int cnt;
        int ovr;
        logic [23:0] v;
        logic [23:0] cap;
        do_reset();
        wr_coef(5'd0, 16'h4000);
        ovr = 0;
        for (int s = 1; s <= 8; s++) begin
            v = 24'(s * 24'h000111);
            send(v);
            checks++; if (d4_busy !== (s % 4 == 0)) begin errors++; $display("FAIL decim_busy_%0d: got %b want %b", s, d4_busy, (s % 4 == 0)); end
            cnt = 0;
            cap = '0;
            for (int j = 0; j < 29; j++) begin
                if (d4_rdy) begin cnt++; cap = d4_out; end
                if (d4_overrun) ovr++;
                step(1);
            end
            checks++; if (cnt !== ((s % 4 == 0) ? 1 : 0)) begin errors++; $display("FAIL decim_count_%0d: got %0d want %0d", s, cnt, (s % 4 == 0) ? 1 : 0); end
            if (s % 4 == 0) begin
                checks++; if (cap !== v) begin errors++; $display("FAIL decim_value_%0d: got %h want %h", s, cap, v); end
            end
        end
        checks++; if (ovr !== 0) begin errors++; $display("FAIL decim_overrun: got %0d want 0", ovr); end
    endtask

    task automatic test_mid_reset();
        int lat;
        int seen;
        logic [23:0] val;
        do_reset();
        wr_coef(5'd0, 16'h4000);
        send(24'h000500);
        step(10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (data_out !== 24'h0) begin errors++; $display("FAIL midrst_data: got %h want 000000", data_out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (data_out_rdy) seen++;
            step(1);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_out: got %0d pulses want 0", seen); end
        wr_coef(5'd0, 16'h4000);
        send(24'h000400);
        enable = 1'b0;
        wr_coef(5'd0, 16'h1000);
        wr_coef(5'd0, 16'h2000);
        wait_out(lat, val);
        checks++; if (val !== 24'h000400) begin errors++; $display("FAIL pend_old_coef: got %h want 000400", val); end
        checks++; if (lat < 0) begin errors++; $display("FAIL enable_drop_out: got %0d want result delivered", lat); end
        enable = 1'b1;
        send(24'h000400);
        wait_out(lat, val);
        checks++; if (val !== 24'h000200) begin errors++; $display("FAIL pend_new_coef: got %h want 000200", val); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_negative();
        test_saturation();
        test_overrun();
        test_decim();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
